// File: rtl/tfab_stream_pkg.sv
// Shared definitions for the fabric result stream: header layout and FSM encodings.
// Also used by the DMA loader that parses these packets.
package tfab_stream_pkg;

  localparam logic [15:0] HdrMagic = 16'hFAB0;

  // HDR1 field positions
  localparam int unsigned HdrLaneLsb = 16;
  localparam int unsigned HdrTileLsb = 8;
  localparam int unsigned HdrOvfBit  = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr0 = 2'd1,
    StHdr1 = 2'd2,
    StData = 2'd3
  } stream_state_e;

  function automatic logic [31:0] hdr0_word(input logic [15:0] seq);
    return {HdrMagic, seq};
  endfunction

endpackage

// File: rtl/fabric_result_streamer.sv
// Snapshots per-lane accumulators on frame_done and streams them out as a
// two-word header followed by the unmasked lanes, tile-major, lane ascending.
module fabric_result_streamer
  import tfab_stream_pkg::*;
#(
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned LANES     = 15,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 frame_done,
  input  logic [NUM_TILES-1:0]                 tile_mask,
  input  logic [LANES-1:0]                     lane_mask,
  input  logic [NUM_TILES*LANES*ACC_WIDTH-1:0] vector_results,
  input  logic [NUM_TILES*LANES-1:0]           overflow_flags,
  output logic [31:0]                          m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 busy,
  output logic [7:0]                           frames_dropped
);

  localparam int unsigned NumIdx = NUM_TILES * LANES;
  localparam int unsigned IdxW   = (NumIdx > 1) ? $clog2(NumIdx) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumIdx - 1);

  stream_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [15:0]     seq_q, seq_d;
  logic [7:0]      dropped_q, dropped_d;
  logic            capture;

  // Snapshot of the engine outputs, loaded only when a frame is accepted
  logic [NumIdx*ACC_WIDTH-1:0] res_q;
  logic [NumIdx-1:0]           ovf_q;
  logic [NUM_TILES-1:0]        tile_q;
  logic [LANES-1:0]            lane_q;

  logic [NumIdx-1:0]    active;
  logic                 any_active;
  logic                 later_active;
  logic                 ovf_any;
  logic                 handshake;
  logic [31:0]          hdr1_word;
  logic [ACC_WIDTH-1:0] lane_word;

  always_ff @(posedge clk) begin
    if (capture) begin
      res_q  <= vector_results;
      ovf_q  <= overflow_flags;
      tile_q <= tile_mask;
      lane_q <= lane_mask;
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned t = 0; t < NUM_TILES; t++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        active[t*LANES + l] = tile_q[t] & lane_q[l];
      end
    end
  end

  assign any_active = |active;
  assign ovf_any    = |(ovf_q & active);

  // tlast goes on the current word when no active index remains after it
  always_comb begin
    later_active = 1'b0;
    for (int unsigned i = 0; i < NumIdx; i++) begin
      if (i > 32'(idx_q)) begin
        later_active = later_active | active[i];
      end
    end
  end

  always_comb begin
    hdr1_word                          = '0;
    hdr1_word[HdrLaneLsb +: LANES]     = lane_q;
    hdr1_word[HdrTileLsb +: NUM_TILES] = tile_q;
    hdr1_word[HdrOvfBit]               = ovf_any;
  end

  assign lane_word = res_q[idx_q*ACC_WIDTH +: ACC_WIDTH];
  assign handshake = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      seq_q     <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    dropped_d = dropped_q;
    capture   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_done) begin
          capture = 1'b1;
          state_d = StHdr0;
        end
      end
      StHdr0: begin
        if (m_axis_tready) state_d = StHdr1;
      end
      StHdr1: begin
        if (m_axis_tready) begin
          idx_d   = '0;
          state_d = any_active ? StData : StIdle;
        end
      end
      StData: begin
        // Masked indices advance without waiting for tready; the walk always
        // covers every index so packet latency does not depend on the masks.
        if (!active[idx_q] || m_axis_tready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (handshake && m_axis_tlast) seq_d = seq_q + 16'd1;

    if (frame_done && (state_q != StIdle) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StHdr0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr0_word(seq_q);
      end
      StHdr1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr1_word;
        m_axis_tlast  = ~any_active;
      end
      StData: begin
        m_axis_tvalid = active[idx_q];
        m_axis_tdata  = lane_word;
        m_axis_tlast  = active[idx_q] & ~later_active;
      end
      default: ;
    endcase
  end

  assign busy           = (state_q != StIdle);
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_fabric_result_streamer.sv
// Bench for fabric_result_streamer: table-driven packets, random packets against
// a queue-based packet model, plus drop, mid-packet reset and saturation sequences.
module tb_fabric_result_streamer;

  localparam int NT = 4;
  localparam int NL = 15;
  localparam int NI = NT * NL;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_done = 1'b0;
  logic [NT-1:0]     tile_mask = '0;
  logic [NL-1:0]     lane_mask = '0;
  logic [NI*32-1:0]  vector_results = '0;
  logic [NI-1:0]     overflow_flags = '0;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              busy;
  logic [7:0]        frames_dropped;

  always #5 clk = ~clk;

  fabric_result_streamer #(
    .NUM_TILES(NT),
    .LANES    (NL),
    .ACC_WIDTH(32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_done    (frame_done),
    .tile_mask     (tile_mask),
    .lane_mask     (lane_mask),
    .vector_results(vector_results),
    .overflow_flags(overflow_flags),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frames_dropped(frames_dropped)
  );

  typedef struct {
    logic [NT-1:0] tm;
    logic [NL-1:0] lm;
    logic [NI-1:0] ov;
    bit            rnd;
    int            words;
    logic [31:0]   hdr0;
    logic [31:0]   hdr1;
    int            cyc;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_seq = 0;
  int          exp_dropped = 0;
  logic [31:0] res_arr [NI];
  logic [32:0] got_q [$];
  logic [32:0] exp_q [$];
  bit          collect = 1'b0;
  bit          rand_ready = 1'b0;
  bit          hold_low = 1'b0;
  bit          stall = 1'b0;
  logic [32:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink: drives tready, records accepted words, checks that stalled words hold
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) stall = 1'b0;
      else if (stall)
        check("stall_hold", {30'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {30'd0, 1'b1, held});
      if (hold_low) m_axis_tready = 1'b0;
      else if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      else m_axis_tready = 1'b1;
      if (collect && m_axis_tvalid && m_axis_tready)
        got_q.push_back({m_axis_tlast, m_axis_tdata});
      stall = reset_n && m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tlast, m_axis_tdata};
    end
  end

  // Packet model: header words, then every enabled lane in tile/lane order
  function automatic void build_exp(input logic [NT-1:0] tm, input logic [NL-1:0] lm,
                                    input logic [NI-1:0] ov, input int seq);
    bit          any_ovf = 1'b0;
    logic [31:0] h1;
    logic [32:0] tail;
    exp_q.delete();
    exp_q.push_back({1'b0, 16'hFAB0, 16'(seq)});
    for (int t = 0; t < NT; t++)
      for (int l = 0; l < NL; l++)
        if (tm[t] && lm[l]) begin
          exp_q.push_back({1'b0, res_arr[t*NL + l]});
          if (ov[t*NL + l]) any_ovf = 1'b1;
        end
    h1 = (32'(lm) << 16) | (32'(tm) << 8) | 32'(any_ovf);
    exp_q.insert(1, {1'b0, h1});
    tail = exp_q.pop_back();
    tail[32] = 1'b1;
    exp_q.push_back(tail);
  endfunction

  task automatic drive_inputs(input logic [NT-1:0] tm, input logic [NL-1:0] lm,
                              input logic [NI-1:0] ov);
    tile_mask      = tm;
    lane_mask      = lm;
    overflow_flags = ov;
    for (int i = 0; i < NI; i++) vector_results[i*32 +: 32] = res_arr[i];
  endtask

  task automatic run_packet(input logic [NT-1:0] tm, input logic [NL-1:0] lm,
                            input logic [NI-1:0] ov, input bit rnd, input bit inject,
                            output int cycles);
    build_exp(tm, lm, ov, exp_seq);
    rand_ready = rnd;
    got_q.delete();
    collect = 1'b1;
    @(negedge clk);
    drive_inputs(tm, lm, ov);
    frame_done = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      frame_done = 1'b0;
      cycles++;
      if (cycles == 2) begin
        tile_mask      = ~tm;
        lane_mask      = ~lm;
        overflow_flags = ~ov;
        for (int i = 0; i < NI; i++) vector_results[i*32 +: 32] = $urandom;
      end
      if (inject && (cycles == 5 || (m_axis_tvalid && m_axis_tlast))) frame_done = 1'b1;
    end while (busy && cycles < 4000);
    collect = 1'b0;
    rand_ready = 1'b0;
    check("packet_done", {63'd0, busy}, 64'd0);
    exp_seq++;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), (i < got_q.size()) ? got_q[i] : 33'bx, exp_q[i]);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int cyc;
    for (int i = 0; i < NI; i++) res_arr[i] = 32'(100 + i);
    run_packet(v.tm, v.lm, v.ov, v.rnd, 1'b0, cyc);
    check({tag, "_words"}, got_q.size(), v.words);
    check({tag, "_hdr0"}, (got_q.size() > 0) ? got_q[0] : 33'bx, {1'b0, v.hdr0});
    check({tag, "_hdr1"}, (got_q.size() > 1) ? got_q[1][31:0] : 32'bx, v.hdr1);
    check({tag, "_tlast"}, (got_q.size() >= v.words) ? got_q[v.words-1][32] : 1'bx, 1);
    if (v.cyc >= 0) check({tag, "_cycles"}, cyc, v.cyc);
    compare_model(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [6];
    vec_t extra;
    int   cyc;
    int   tl_cnt;

    tbl[0] = '{4'hF, 15'h7FFF, 60'd0, 1'b0, 62, 32'hFAB00000, 32'h7FFF0F00, 63};
    tbl[1] = '{4'h4, 15'h0005, 60'd0, 1'b0, 4,  32'hFAB00001, 32'h00050400, 63};
    tbl[2] = '{4'h0, 15'h7FFF, 60'd0, 1'b0, 2,  32'hFAB00002, 32'h7FFF0000, 3};
    tbl[3] = '{4'hF, 15'h7FFF, 60'd0, 1'b1, 62, 32'hFAB00003, 32'h7FFF0F00, -1};
    tbl[4] = '{4'h1, 15'h0001, 60'd2, 1'b0, 3,  32'hFAB00004, 32'h00010100, 63};
    tbl[5] = '{4'h1, 15'h0001, 60'd1, 1'b0, 3,  32'hFAB00005, 32'h00010101, 63};

    repeat (3) @(negedge clk);
    check("rst_tvalid_in", {63'd0, m_axis_tvalid}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 0);
    check("rst_tlast", {63'd0, m_axis_tlast}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_tdata", {32'd0, m_axis_tdata}, 0);
    check("rst_dropped", {56'd0, frames_dropped}, 0);

    for (int k = 0; k < 6; k++) apply_vec(tbl[k], $sformatf("vec%0d", k));

    for (int k = 0; k < 6; k++) begin
      logic [NT-1:0] tm;
      logic [NL-1:0] lm;
      logic [NI-1:0] ov;
      tm = NT'($urandom);
      lm = NL'($urandom);
      ov = {28'($urandom), $urandom};
      for (int i = 0; i < NI; i++) res_arr[i] = $urandom;
      run_packet(tm, lm, ov, 1'b1, 1'b0, cyc);
      compare_model($sformatf("rand%0d", k));
    end

    // Two drops: one early in the packet, one on the tlast handshake
    for (int i = 0; i < NI; i++) res_arr[i] = 32'(100 + i);
    run_packet(4'hF, 15'h7FFF, 60'd0, 1'b0, 1'b1, cyc);
    exp_dropped += 2;
    check("drop_count", {56'd0, frames_dropped}, 64'(exp_dropped));
    check("drop_cycles", cyc, 63);
    compare_model("drop");

    // Reset in the middle of a packet
    got_q.delete();
    collect = 1'b1;
    @(negedge clk);
    drive_inputs(4'hF, 15'h7FFF, 60'd0);
    frame_done = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      frame_done = 1'b0;
      cyc++;
      if (cyc == 3) frame_done = 1'b1;
    end while (got_q.size() < 10 && cyc < 200);
    exp_dropped++;
    check("pre_reset_dropped", {56'd0, frames_dropped}, 64'(exp_dropped));
    reset_n = 1'b0;
    #1;
    check("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 0);
    check("mid_rst_busy", {63'd0, busy}, 0);
    check("mid_rst_dropped", {56'd0, frames_dropped}, 0);
    collect = 1'b0;
    tl_cnt = 0;
    foreach (got_q[i]) if (got_q[i][32]) tl_cnt++;
    check("abandon_no_tlast", tl_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_seq = 0;
    exp_dropped = 0;

    extra = '{4'h0, 15'h0003, 60'd0, 1'b0, 2, 32'hFAB00000, 32'h00030000, 3};
    apply_vec(extra, "post_rst");
    extra = '{4'hF, 15'h7FFF, 60'd0, 1'b0, 62, 32'hFAB00001, 32'h7FFF0F00, 63};
    apply_vec(extra, "post_rst2");

    // frames_dropped saturation while the sink stalls
    for (int i = 0; i < NI; i++) res_arr[i] = $urandom;
    build_exp(4'hF, 15'h7FFF, 60'd0, exp_seq);
    got_q.delete();
    collect = 1'b1;
    hold_low = 1'b1;
    @(negedge clk);
    drive_inputs(4'hF, 15'h7FFF, 60'd0);
    frame_done = 1'b1;
    repeat (300) @(negedge clk);
    frame_done = 1'b0;
    check("sat_dropped", {56'd0, frames_dropped}, 255);
    hold_low = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 4000);
    collect = 1'b0;
    check("sat_done", {63'd0, busy}, 0);
    check("sat_dropped_hold", {56'd0, frames_dropped}, 255);
    compare_model("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fabric_result_streamer.md
FABRIC_RESULT_STREAMER -- requirements
Module: fabric_result_streamer

Interface
REQ-001 SHALL have parameter NUM_TILES, default 4, number of tiles; legal range 1..8.
REQ-002 SHALL have parameter LANES, default 15, lanes per tile; legal range 1..16.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, accumulator width per lane; fixed at 32.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: `clk  input  1  sole clock; all state on rising edge`.
REQ-005 SHALL have `reset_n  input  1  asynchronous active-low reset`.
REQ-006 SHALL have `frame_done  input  1  one-cycle pulse; engine frame complete`.
REQ-007 SHALL have `tile_mask  input  NUM_TILES  tiles to drain`.
REQ-008 SHALL have `lane_mask  input  LANES  lanes to drain per tile`.
REQ-009 SHALL have `vector_results  input  NUM_TILES*LANES*32  accumulators; tile t lane l at bit offset (t*LANES+l)*32`.
REQ-010 SHALL have `overflow_flags  input  NUM_TILES*LANES  per-lane overflow, same index order`.
REQ-011 SHALL have `m_axis_tdata  output  32  stream data`.
REQ-012 SHALL have `m_axis_tvalid  output  1  stream valid`.
REQ-013 SHALL have `m_axis_tready  input  1  stream ready`.
REQ-014 SHALL have `m_axis_tlast  output  1  last word of frame packet`.
REQ-015 SHALL have `busy  output  1  high in any state other than IDLE`.
REQ-016 SHALL have `frames_dropped  output  8  saturating count of frame_done pulses ignored while busy`.

Function
REQ-017 SHALL implement the states IDLE, HDR0, HDR1 and DATA.
REQ-018 In IDLE, a frame_done pulse SHALL snapshot vector_results, overflow_flags, tile_mask and lane_mask into shadow registers, enter HDR0, and assert tvalid on the next cycle.
REQ-019 The HDR0 word SHALL be {16'hFAB0, seq[15:0]}, where seq is the count of accepted frames since reset, starting at 0 and wrapping at 16 bits.
REQ-020 The HDR1 word SHALL be laid out as:
- [31:16] snapshot lane_mask, zero-extended;
- [15:8] snapshot tile_mask, zero-extended;
- [0] OR of overflow over all lanes with both tile and lane bits set;
- all other bits 0.
REQ-021 The DATA state SHALL walk index t*LANES+l in tile-major order with lane ascending, from 0 to NUM_TILES*LANES-1, one index per cycle.
REQ-022 A masked-off index SHALL be skipped in one cycle with tvalid low.
REQ-023 Each active index SHALL present that lane's 32-bit snapshot result.
REQ-024 tlast SHALL be asserted on the final active data word.
REQ-025 If no index is active, tlast SHALL be asserted on HDR1 and the DATA state SHALL be skipped.
REQ-026 A word SHALL transfer only when tvalid && tready.
- While tvalid && !tready, tdata, tlast and the state SHALL hold.
- tvalid SHALL NOT deassert until the transfer completes.
REQ-027 After the tlast word transfers, the block SHALL return to IDLE, increment seq, and deassert busy on the next cycle.
REQ-028 A frame_done that coincides with the tlast handshake SHALL count as dropped.
REQ-029 A frame_done while busy SHALL NOT disturb the snapshot or the stream.
- It SHALL increment frames_dropped, saturating at 255.
REQ-030 Snapshot registers SHALL load only on an accepted frame_done; input changes after capture SHALL NOT affect the output.
REQ-031 Total cycles from accept to IDLE with tready held high SHALL equal 2 + NUM_TILES*LANES + 1, independent of the masks.

Reset
REQ-032 On reset_n low, the block SHALL asynchronously clear:
- state to IDLE;
- tvalid, tlast, busy and tdata to 0;
- seq and frames_dropped to 0;
- the walk index to 0.
REQ-033 A reset asserted mid-packet SHALL abandon the packet without emitting tlast; the first packet after reset SHALL carry seq 0.
REQ-034 Snapshot registers need no reset value; they are never observable before a capture.

Structure
REQ-035 Shared package tfab_stream_pkg SHALL hold:
- header magic 16'hFAB0;
- header bit positions;
- state encodings.
The DMA loader SHALL reuse it.
REQ-036 The block SHALL be one module; no sub-module is required.
REQ-037 Lane select SHALL be an indexed part-select of the snapshot register.

Verification
REQ-038 All masks set, NUM_TILES=4, LANES=15, results[i]=i+100, tready=1 -> the bench SHALL check:
- 62 words: FAB00000, 7FFF0F00, then 100..159;
- tlast on word 62;
- busy low 63 cycles after the pulse.
REQ-039 tile_mask=4'b0100, lane_mask=15'h0005 -> the bench SHALL check 4 words: header0, 00050400, results[30], results[32]; tlast on results[32].
REQ-040 tile_mask=0 -> the bench SHALL check exactly 2 words with tlast on HDR1, then seq=1 on the next packet.
REQ-041 tready toggled with a random 50% pattern, all masks set -> the bench SHALL check the identical 62-word sequence with tdata stable during stalls.
REQ-042 A second frame_done at cycle 5 of a packet, and one coincident with tlast -> the bench SHALL check frames_dropped=2 and the current packet unchanged.
REQ-043 Overflow on a masked lane only -> the bench SHALL check HDR1[0]=0; on an active lane -> HDR1[0]=1.
REQ-044 reset_n pulsed low at word 10 -> the bench SHALL check tvalid=0 immediately, frames_dropped=0, and the next packet header FAB00000.
